// File: rtl/pwm_pkg.sv
// Shared PWM constants and the capture FSM state type (also used by the PWM generator).
package pwm_pkg;

  localparam int unsigned PWM_PERIOD = 256;
  localparam int unsigned SAMPLE_W   = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } cap_state_e;

endpackage

// File: rtl/pwm_in_conditioner.sv
// Input conditioner for the asynchronous PWM line: synchronizer, optional
// 3-sample majority glitch filter (macro PWM_CAPTURE_GLITCH_FILTER_EN), and a
// "primed" flag that rises once the pipeline holds only post-reset samples.
module pwm_in_conditioner #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pwm_in,
  output logic level,
  output logic primed
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Metastability synchronizer chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  // Filter adds two cycles; priming waits until the filter window is fully refilled.
  localparam int unsigned PRIME_DEPTH = SYNC_STAGES + 3;

  logic [1:0] hist_q;
  logic       filt_q;
  logic       sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Majority vote over the last three synchronized samples; single-cycle pulses vanish.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_s};
      filt_q <= (sync_s & hist_q[0]) | (sync_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end
  end

  assign level = filt_q;
`else
  localparam int unsigned PRIME_DEPTH = SYNC_STAGES;

  assign level = sync_q[SYNC_STAGES-1];
`endif

  logic [PRIME_DEPTH-1:0] prime_q;

  // Marks when level no longer reflects reset-cleared flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prime_q <= '0;
    else          prime_q <= {prime_q[PRIME_DEPTH-2:0], 1'b1};
  end

  assign primed = prime_q[PRIME_DEPTH-1];

endmodule

// File: rtl/pwm_capture.sv
// PWM duty capture: measures the high time of each period of an asynchronous
// PWM line and offers it as an 8-bit sample over a valid/ready handshake.
// Optional glitch filter enabled by defining PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD      = PWM_PERIOD,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pwm_in,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                stuck_high,
  output logic                overrun
);

  localparam int unsigned     CNT_W   = $clog2(PERIOD) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic level;
  logic primed;
  logic level_d;
  logic rise_c;
  logic fall_c;

  cap_state_e       state_q, state_c;
  logic [CNT_W-1:0] high_q, high_c;
  logic [CNT_W-1:0] per_q, per_c;
  logic [CNT_W-1:0] low_q, low_c;
  logic             stuck_c;
  logic             emit_c;
  logic [SAMPLE_W-1:0] emit_val_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  pwm_in_conditioner #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cond (
    .clk    (clk),
    .reset_n(reset_n),
    .pwm_in (pwm_in),
    .level  (level),
    .primed (primed)
  );

  // Delayed copy of the conditioned line for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) level_d <= 1'b0;
    else          level_d <= level;
  end

  assign rise_c = level & ~level_d;
  assign fall_c = ~level & level_d;

  // FSM state, counters and stuck flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      high_q     <= '0;
      per_q      <= '0;
      low_q      <= '0;
      stuck_high <= 1'b0;
    end else begin
      state_q    <= state_c;
      high_q     <= high_c;
      per_q      <= per_c;
      low_q      <= low_c;
      stuck_high <= stuck_c;
    end
  end

  // Next state, counter updates and sample emission.
  always_comb begin
    state_c    = state_q;
    high_c     = high_q;
    per_c      = per_q;
    low_c      = low_q;
    stuck_c    = stuck_high;
    emit_c     = 1'b0;
    emit_val_c = '0;

    case (state_q)
      IDLE: begin
        // Only start after a low, so a period already in progress is never measured.
        if (primed && !level) begin
          state_c = WAIT_RISE;
          low_c   = CNT_ONE;
        end
      end

      WAIT_RISE, LOW: begin
        if (rise_c) begin
          state_c = HIGH;
          high_c  = CNT_ONE;
          per_c   = CNT_ONE;
          low_c   = '0;
        end else begin
          if (state_q == LOW) per_c = sat_inc(per_q);
          if (low_q + CNT_ONE == CNT_MAX) begin
            emit_c = 1'b1;
            low_c  = '0;
          end else begin
            low_c = low_q + CNT_ONE;
          end
        end
      end

      HIGH: begin
        if (fall_c) begin
          // A fall ending a stuck-high episode produces no sample.
          if (!stuck_high) begin
            emit_c     = 1'b1;
            emit_val_c = SAMPLE_W'(high_q);
          end
          stuck_c = 1'b0;
          state_c = LOW;
          low_c   = CNT_ONE;
          per_c   = sat_inc(per_q);
        end else begin
          high_c = sat_inc(high_q);
          per_c  = sat_inc(per_q);
          if (!stuck_high && sat_inc(high_q) == CNT_MAX) begin
            emit_c     = 1'b1;
            emit_val_c = '1;
            stuck_c    = 1'b1;
          end
        end
      end

      default: state_c = IDLE;
    endcase
  end

  // Output holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (emit_c) begin
      if (!sample_valid || sample_ready) begin
        sample_data  <= emit_val_c;
        sample_valid <= 1'b1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: directed scenarios plus randomized
// duty/ready traffic, checked cycle by cycle against a run-length reference model.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int S   = 2;
  localparam int PER = 256;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int PD  = S + 3;
`else
  localparam int PD  = S;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pwm_in;
  logic       sample_ready;
  logic [7:0] sample_data;
  logic       sample_valid;
  logic       stuck_high;
  logic       overrun;

  always #5 clk = ~clk;

  pwm_capture #(.PERIOD(PER), .SYNC_STAGES(S)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .pwm_in      (pwm_in),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .stuck_high  (stuck_high),
    .overrun     (overrun)
  );

  int errs   = 0;
  int checks = 0;
  bit rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model state: line history, run lengths, expected outputs.
  logic [15:0] hv;
  int  e_cnt;
  bit  armed, prev, m_stuck;
  int  high_run, low_run;
  bit  ev, eo;
  int  ed;
  int  xq[$];

  task automatic model_reset();
    hv = '0; e_cnt = 0; armed = 0; prev = 0; m_stuck = 0;
    high_run = 0; low_run = 0; ev = 0; eo = 0; ed = 0;
  endtask

  task automatic model_step();
    logic line;
    bit   emit;
    int   val;
    emit = 0;
    val  = 0;
    if (sample_valid && sample_ready) xq.push_back(int'(sample_data));
    hv = {hv[14:0], pwm_in};
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    line = (hv[S+1] & hv[S+2]) | (hv[S+1] & hv[S+3]) | (hv[S+2] & hv[S+3]);
`else
    line = hv[S];
`endif
    if (!armed) begin
      if (e_cnt >= PD && !line) begin armed = 1; low_run = 1; end
    end else if (line && !prev) begin
      high_run = 1;
    end else if (line) begin
      if (high_run < PER) high_run++;
      if (high_run == PER && !m_stuck) begin emit = 1; val = 255; m_stuck = 1; end
    end else if (prev) begin
      if (!m_stuck) begin emit = 1; val = high_run; end
      m_stuck = 0;
      low_run = 1;
    end else begin
      low_run++;
      if (low_run == PER) begin emit = 1; val = 0; low_run = 0; end
    end
    if (emit) begin
      if (!ev || sample_ready) begin ev = 1; ed = val; end
      else eo = 1;
    end else if (ev && sample_ready) begin
      ev = 0;
    end
    prev = line;
    if (e_cnt < 1000) e_cnt++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("valid", sample_valid, ev);
        if (ev) check("data", sample_data, ed);
        check("stuck", stuck_high, m_stuck);
        check("overrun", overrun, eo);
      end
    end
  end

  task automatic tick(input logic v);
    pwm_in = v;
    if (rnd_ready) sample_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) tick(v);
  endtask

  task automatic period(input int duty);
    for (int i = 0; i < PER; i++) tick(i < duty);
  endtask

  task automatic check_log(input string tag, input int want[$]);
    check({tag, "_n"}, xq.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      check({tag, "_v"}, (i < xq.size()) ? xq[i] : -1, want[i]);
  endtask

  initial begin
    int sweep[3];
    int w[$];
    reset_n = 1'b0;
    pwm_in = 1'b0;
    sample_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", sample_valid, 0);
    check("rst_data", sample_data, 0);
    check("rst_stuck", stuck_high, 0);
    check("rst_ovr", overrun, 0);
    reset_n = 1'b1;

    // Steady duty 100: first partial period ignored, then one sample per period.
    xq.delete();
    repeat (4) period(100);
    hold(0, 8);
    check_log("p100", '{100, 100, 100});

    // Duty sweep with consumer always ready.
    sweep = '{1, 128, 255};
    xq.delete();
    foreach (sweep[k]) repeat (2) period(sweep[k]);
    hold(0, 8);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    check_log("sweep", '{1, 1, 128, 128, 255, 255});
`endif
    check("sweep_ovr", overrun, 0);

    // Constant low: a zero sample every PERIOD low cycles.
    xq.delete();
    hold(0, 600);
    check_log("low", '{0, 0});
    check("low_stuck", stuck_high, 0);

    // Stuck high then release.
    xq.delete();
    hold(1, 300);
    check("stk_flag", stuck_high, 1);
    check_log("stk", '{255});
    hold(0, 8);
    check("stk_clr", stuck_high, 0);
    check_log("stk_rel", '{255});

    // Consumer stalled across two periods.
    sample_ready = 1'b0;
    xq.delete();
    period(50);
    period(60);
    hold(0, 8);
    check("ovr_data", sample_data, 50);
    check("ovr_valid", sample_valid, 1);
    check("ovr_flag", overrun, 1);
    sample_ready = 1'b1;
    hold(0, 4);
    period(60);
    hold(0, 8);
    check_log("ovr_log", '{50, 60});

    // Reset in the middle of a high phase, then a one-cycle glitch.
    hold(1, 20);
    #2 reset_n = 1'b0;
    #1;
    check("rst2_valid", sample_valid, 0);
    check("rst2_data", sample_data, 0);
    check("rst2_ovr", overrun, 0);
    check("rst2_stuck", stuck_high, 0);
    hold(1, 3);
    reset_n = 1'b1;
    xq.delete();
    hold(1, 40);
    hold(0, 30);
    hold(1, 1);
    hold(0, 30);
    period(80);
    hold(0, 8);
    w.delete();
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    w.push_back(1);
`endif
    w.push_back(80);
    check_log("glitch", w);

    // Randomized duties and consumer back-pressure.
    rnd_ready = 1'b1;
    for (int k = 0; k < 25; k++) begin
      period(int'($urandom_range(0, 255)));
      if (k % 8 == 7) begin
        hold(1, int'($urandom_range(250, 270)));
        hold(0, int'($urandom_range(200, 300)));
      end
    end
    rnd_ready = 1'b0;
    sample_ready = 1'b1;
    hold(0, 10);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
